// File: rtl/exception_trap_controller_pkg.sv
// Shared codes and FSM states for the exception trap controller.
// Imported by the selector, the controller and its interface users.
package exception_trap_controller_pkg;

  localparam logic [3:0] NO_E          = 4'h0;
  localparam logic [3:0] E_INST_FAULT  = 4'h1;
  localparam logic [3:0] E_ILLEGAL     = 4'h2;
  localparam logic [3:0] E_BREAK       = 4'h3;
  localparam logic [3:0] E_LOAD_MIS    = 4'h4;
  localparam logic [3:0] E_LOAD_FAULT  = 4'h5;
  localparam logic [3:0] E_STORE_MIS   = 4'h6;
  localparam logic [3:0] E_STORE_FAULT = 4'h7;
  localparam logic [3:0] E_ECALL       = 4'h8;

  localparam int FCNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_REDIRECT = 3'd2,
    ST_TRAP     = 3'd3,
    ST_RET      = 3'd4,
    ST_HALT     = 3'd5
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exception_trap_controller_if.sv
// Pipeline <-> trap controller bundle: exception codes, mret/mepc
// writes in; flush, redirect, CSR state and status out.
interface exception_trap_controller_if #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int CODE_W  = 4,
  parameter int CNT_W   = 8
);

  logic [NUM_SRC*CODE_W-1:0] i_exc_code;
  logic [NUM_SRC*XLEN-1:0]   i_exc_pc;
  logic [NUM_SRC*XLEN-1:0]   i_exc_tval;
  logic                      i_mret;
  logic                      i_mepc_wr;
  logic [XLEN-1:0]           i_mepc_wdata;

  logic [NUM_SRC-1:0]        o_flush;
  logic                      o_redirect;
  logic [XLEN-1:0]           o_redirect_pc;
  logic [XLEN-1:0]           o_mepc;
  logic [XLEN-1:0]           o_mtval;
  logic [CODE_W-1:0]         o_mcause;
  logic                      o_trap_permission;
  logic                      o_halt;
  logic [CNT_W-1:0]          o_exc_count;

  modport master (
    output i_exc_code, i_exc_pc, i_exc_tval,
    output i_mret, i_mepc_wr, i_mepc_wdata,
    input  o_flush, o_redirect, o_redirect_pc,
    input  o_mepc, o_mtval, o_mcause,
    input  o_trap_permission, o_halt, o_exc_count
  );

  modport slave (
    input  i_exc_code, i_exc_pc, i_exc_tval,
    input  i_mret, i_mepc_wr, i_mepc_wdata,
    output o_flush, o_redirect, o_redirect_pc,
    output o_mepc, o_mtval, o_mcause,
    output o_trap_permission, o_halt, o_exc_count
  );

endinterface

// File: rtl/exception_trap_controller_sel.sv
// Oldest-first exception selector: the highest-index stage with a
// nonzero code wins; outputs valid, index and the winner's code/pc/tval.
module exception_trap_controller_sel
  import exception_trap_controller_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int CODE_W  = 4,
  parameter int IDX_W   = idx_w(NUM_SRC)
) (
  input  logic [NUM_SRC*CODE_W-1:0] code_i,
  input  logic [NUM_SRC*XLEN-1:0]   pc_i,
  input  logic [NUM_SRC*XLEN-1:0]   tval_i,
  output logic                      valid_o,
  output logic [IDX_W-1:0]          idx_o,
  output logic [CODE_W-1:0]         code_o,
  output logic [XLEN-1:0]           pc_o,
  output logic [XLEN-1:0]           tval_o
);

  // Ascending scan: a later (older) hit overrides earlier ones.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    code_o  = '0;
    pc_o    = '0;
    tval_o  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (|code_i[k*CODE_W +: CODE_W]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(k);
        code_o  = code_i[k*CODE_W +: CODE_W];
        pc_o    = pc_i[k*XLEN +: XLEN];
        tval_o  = tval_i[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/exception_trap_controller.sv
// Trap sequencer: flush, latch mepc/mcause/mtval, redirect, handler, mret.
// Ports: i_clk, i_rst_n (sync, active low), bus (slave modport).
module exception_trap_controller
  import exception_trap_controller_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              NUM_SRC   = 2,
  parameter int              CODE_W    = 4,
  parameter int              FLUSH_CYC = 2,
  parameter logic [XLEN-1:0] TRAP_VEC  = '0,
  parameter int              CNT_W     = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  exception_trap_controller_if.slave  bus
);

  localparam int IDX_W = idx_w(NUM_SRC);

  state_e              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [NUM_SRC-1:0]  mask_q, mask_d;
  logic [XLEN-1:0]     mepc_q, mepc_d;
  logic [XLEN-1:0]     mtval_q, mtval_d;
  logic [CODE_W-1:0]   mcause_q, mcause_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                win_v;
  logic [IDX_W-1:0]    win_idx;
  logic [CODE_W-1:0]   win_code;
  logic [XLEN-1:0]     win_pc;
  logic [XLEN-1:0]     win_tval;
  logic [NUM_SRC-1:0]  win_mask;
  logic [CNT_W-1:0]    count_inc;

  logic [NUM_SRC-1:0]  flush;
  logic                redirect;
  logic [XLEN-1:0]     redirect_pc;
  logic                perm;
  logic                halt;

  exception_trap_controller_sel #(
    .XLEN    (XLEN),
    .NUM_SRC (NUM_SRC),
    .CODE_W  (CODE_W),
    .IDX_W   (IDX_W)
  ) u_sel (
    .code_i  (bus.i_exc_code),
    .pc_i    (bus.i_exc_pc),
    .tval_i  (bus.i_exc_tval),
    .valid_o (win_v),
    .idx_o   (win_idx),
    .code_o  (win_code),
    .pc_o    (win_pc),
    .tval_o  (win_tval)
  );

  // Squash the winner and every younger stage behind it.
  always_comb begin
    win_mask = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      win_mask[k] = (k <= int'(win_idx));
    end
  end

  assign count_inc = (&count_q) ? count_q : count_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    mask_d   = mask_q;
    mepc_d   = mepc_q;
    mtval_d  = mtval_q;
    mcause_d = mcause_q;
    count_d  = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_v) begin
          state_d  = ST_FLUSH;
          fcnt_d   = FCNT_W'(FLUSH_CYC - 1);
          mask_d   = win_mask;
          mepc_d   = win_pc;
          mtval_d  = win_tval;
          mcause_d = win_code;
          count_d  = count_inc;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = ST_REDIRECT;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      ST_REDIRECT: state_d = ST_TRAP;
      ST_TRAP: begin
        // A fault inside the handler beats mret and mepc writes.
        if (win_v) begin
          state_d = ST_HALT;
          count_d = count_inc;
        end else begin
          if (bus.i_mepc_wr) mepc_d = bus.i_mepc_wdata;
          if (bus.i_mret) state_d = ST_RET;
        end
      end
      ST_RET:  state_d = ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pure decode of registered state.
  always_comb begin
    flush       = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    perm        = 1'b0;
    halt        = 1'b0;
    unique case (state_q)
      ST_FLUSH: flush = mask_q;
      ST_REDIRECT: begin
        flush       = '1;
        redirect    = 1'b1;
        redirect_pc = TRAP_VEC;
      end
      ST_TRAP: perm = 1'b1;
      ST_RET: begin
        flush       = '1;
        redirect    = 1'b1;
        redirect_pc = mepc_q;
        perm        = 1'b1;
      end
      ST_HALT: begin
        flush = '1;
        halt  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      fcnt_q   <= '0;
      mask_q   <= '0;
      mepc_q   <= '0;
      mtval_q  <= '0;
      mcause_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      mask_q   <= mask_d;
      mepc_q   <= mepc_d;
      mtval_q  <= mtval_d;
      mcause_q <= mcause_d;
      count_q  <= count_d;
    end
  end

  assign bus.o_flush           = flush;
  assign bus.o_redirect        = redirect;
  assign bus.o_redirect_pc     = redirect_pc;
  assign bus.o_mepc            = mepc_q;
  assign bus.o_mtval           = mtval_q;
  assign bus.o_mcause          = mcause_q;
  assign bus.o_trap_permission = perm;
  assign bus.o_halt            = halt;
  assign bus.o_exc_count       = count_q;

endmodule

// File: tb/tb_exception_trap_controller.sv
// Randomized bench for exception_trap_controller; two instances share
// stimulus, one with an 8-bit and one with a 2-bit exception counter.
module tb_exception_trap_controller;

  localparam int          XLEN = 32;
  localparam int          NS   = 2;
  localparam int          CW   = 4;
  localparam int          FC   = 2;
  localparam logic [31:0] TV   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exception_trap_controller_if #(
    .XLEN(XLEN), .NUM_SRC(NS), .CODE_W(CW), .CNT_W(8)
  ) ifa ();
  exception_trap_controller_if #(
    .XLEN(XLEN), .NUM_SRC(NS), .CODE_W(CW), .CNT_W(2)
  ) ifb ();

  assign ifb.i_exc_code   = ifa.i_exc_code;
  assign ifb.i_exc_pc     = ifa.i_exc_pc;
  assign ifb.i_exc_tval   = ifa.i_exc_tval;
  assign ifb.i_mret       = ifa.i_mret;
  assign ifb.i_mepc_wr    = ifa.i_mepc_wr;
  assign ifb.i_mepc_wdata = ifa.i_mepc_wdata;

  exception_trap_controller #(
    .XLEN(XLEN), .NUM_SRC(NS), .CODE_W(CW),
    .FLUSH_CYC(FC), .TRAP_VEC(TV), .CNT_W(8)
  ) dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifa.slave)
  );

  exception_trap_controller #(
    .XLEN(XLEN), .NUM_SRC(NS), .CODE_W(CW),
    .FLUSH_CYC(FC), .TRAP_VEC(TV), .CNT_W(2)
  ) dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifb.slave)
  );

  int          checks;
  int          failures;
  int          n_taken;
  logic [31:0] m_mepc;
  logic [31:0] m_mtval;
  logic [3:0]  m_mcause;

  function automatic logic [7:0] exp_ca();
    return (n_taken > 255) ? 8'hFF : 8'(n_taken);
  endfunction

  function automatic logic [1:0] exp_cb();
    return (n_taken > 3) ? 2'b11 : 2'(n_taken);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ifa.i_exc_code   = '0;
    ifa.i_exc_pc     = '0;
    ifa.i_exc_tval   = '0;
    ifa.i_mret       = 1'b0;
    ifa.i_mepc_wr    = 1'b0;
    ifa.i_mepc_wdata = '0;
  endtask

  task automatic junk_in();
    ifa.i_exc_code   = 8'($urandom);
    ifa.i_exc_pc     = {$urandom, $urandom};
    ifa.i_exc_tval   = {$urandom, $urandom};
    ifa.i_mret       = 1'($urandom);
    ifa.i_mepc_wr    = 1'($urandom);
    ifa.i_mepc_wdata = $urandom;
  endtask

  task automatic model_clear();
    n_taken  = 0;
    m_mepc   = '0;
    m_mtval  = '0;
    m_mcause = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.i_exc_code = 8'h52;
    ifa.i_exc_pc   = {32'h40, 32'h8};
    ifa.i_mret     = 1'b1;
    repeat (3) step();
    model_clear();
    checks++;
    if ({ifa.o_flush, ifa.o_redirect, ifa.o_trap_permission,
         ifa.o_halt} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b%b%b%b want=0",
               ifa.o_flush, ifa.o_redirect,
               ifa.o_trap_permission, ifa.o_halt);
    end
    checks++;
    if ({ifa.o_redirect_pc, ifa.o_mepc, ifa.o_mtval,
         ifa.o_mcause, ifa.o_exc_count} !== '0) begin
      failures++;
      $display("FAIL reset_regs rpc=%h mepc=%h mtval=%h mc=%h cnt=%h want=0",
               ifa.o_redirect_pc, ifa.o_mepc, ifa.o_mtval,
               ifa.o_mcause, ifa.o_exc_count);
    end
    checks++;
    if ({ifb.o_flush, ifb.o_redirect, ifb.o_trap_permission,
         ifb.o_halt, ifb.o_exc_count} !== '0) begin
      failures++;
      $display("FAIL reset_b flush=%b halt=%b cnt=%b want=0",
               ifb.o_flush, ifb.o_halt, ifb.o_exc_count);
    end
    idle_in();
    rst_n = 1'b1;
  endtask

  // Full trap scenario; expectations come from the stated sequence.
  task automatic test_trap_seq(
    input logic [3:0]  c1, c0,
    input logic [31:0] p1, p0, t1, t0,
    input bit          wr, wr_with_mret,
    input logic [31:0] wd,
    input bit          df,
    input string       nm
  );
    int         win;
    logic [1:0] mask;
    win = -1;
    if (c0 != 4'h0) win = 0;
    if (c1 != 4'h0) win = 1;
    ifa.i_exc_code = {c1, c0};
    ifa.i_exc_pc   = {p1, p0};
    ifa.i_exc_tval = {t1, t0};
    step();
    if (win < 0) begin
      idle_in();
      checks++;
      if ({ifa.o_flush, ifa.o_redirect,
           ifa.o_trap_permission} !== 4'b0) begin
        failures++;
        $display("FAIL %s_notrap flush=%b redir=%b perm=%b want=0",
                 nm, ifa.o_flush, ifa.o_redirect,
                 ifa.o_trap_permission);
      end
      return;
    end
    mask     = (win == 1) ? 2'b11 : 2'b01;
    n_taken++;
    m_mcause = (win == 1) ? c1 : c0;
    m_mepc   = (win == 1) ? p1 : p0;
    m_mtval  = (win == 1) ? t1 : t0;
    for (int i = 0; i < FC; i++) begin
      checks++;
      if ({ifa.o_flush, ifa.o_redirect, ifa.o_trap_permission,
           ifa.o_halt} !== {mask, 3'b000}) begin
        failures++;
        $display("FAIL %s_flush%0d got=%b/%b/%b/%b want flush=%b",
                 nm, i, ifa.o_flush, ifa.o_redirect,
                 ifa.o_trap_permission, ifa.o_halt, mask);
      end
      junk_in();
      step();
    end
    checks++;
    if ({ifa.o_flush, ifa.o_redirect, ifa.o_trap_permission,
         ifa.o_halt} !== 5'b11100 || ifa.o_redirect_pc !== TV) begin
      failures++;
      $display("FAIL %s_redirect got=%b/%b/%b/%b pc=%h want 11/1/0/0 pc=%h",
               nm, ifa.o_flush, ifa.o_redirect,
               ifa.o_trap_permission, ifa.o_halt,
               ifa.o_redirect_pc, TV);
    end
    junk_in();
    step();
    idle_in();
    checks++;
    if ({ifa.o_flush, ifa.o_redirect, ifa.o_trap_permission,
         ifa.o_halt} !== 5'b00010) begin
      failures++;
      $display("FAIL %s_trap got=%b/%b/%b/%b want 00/0/1/0",
               nm, ifa.o_flush, ifa.o_redirect,
               ifa.o_trap_permission, ifa.o_halt);
    end
    checks++;
    if (ifa.o_mcause !== m_mcause || ifa.o_mepc !== m_mepc ||
        ifa.o_mtval !== m_mtval) begin
      failures++;
      $display("FAIL %s_csr got mc=%h mepc=%h mtval=%h want %h %h %h",
               nm, ifa.o_mcause, ifa.o_mepc, ifa.o_mtval,
               m_mcause, m_mepc, m_mtval);
    end
    checks++;
    if (ifa.o_exc_count !== exp_ca() ||
        ifb.o_exc_count !== exp_cb()) begin
      failures++;
      $display("FAIL %s_count got a=%0d b=%0d want a=%0d b=%0d",
               nm, ifa.o_exc_count, ifb.o_exc_count,
               exp_ca(), exp_cb());
    end
    repeat ($urandom_range(0, 2)) begin
      step();
      checks++;
      if (ifa.o_trap_permission !== 1'b1) begin
        failures++;
        $display("FAIL %s_hold perm=%b want 1",
                 nm, ifa.o_trap_permission);
      end
    end
    if (df) begin
      ifa.i_exc_code = {4'($urandom_range(0, 15)),
                        4'($urandom_range(1, 15))};
      ifa.i_exc_pc   = {$urandom, $urandom};
      ifa.i_exc_tval = {$urandom, $urandom};
      ifa.i_mret     = 1'b1;
      step();
      idle_in();
      n_taken++;
      checks++;
      if ({ifa.o_flush, ifa.o_redirect, ifa.o_trap_permission,
           ifa.o_halt} !== 5'b11001) begin
        failures++;
        $display("FAIL %s_halt got=%b/%b/%b/%b want 11/0/0/1",
                 nm, ifa.o_flush, ifa.o_redirect,
                 ifa.o_trap_permission, ifa.o_halt);
      end
      checks++;
      if (ifa.o_mcause !== m_mcause || ifa.o_mepc !== m_mepc ||
          ifa.o_mtval !== m_mtval || ifa.o_exc_count !== exp_ca() ||
          ifb.o_exc_count !== exp_cb()) begin
        failures++;
        $display("FAIL %s_halt_csr mc=%h mepc=%h cnt=%0d want %h %h %0d",
                 nm, ifa.o_mcause, ifa.o_mepc, ifa.o_exc_count,
                 m_mcause, m_mepc, exp_ca());
      end
      for (int i = 0; i < 4; i++) begin
        junk_in();
        step();
        checks++;
        if (ifa.o_halt !== 1'b1 || ifa.o_trap_permission !== 1'b0 ||
            ifa.o_redirect !== 1'b0) begin
          failures++;
          $display("FAIL %s_sticky%0d halt=%b perm=%b redir=%b",
                   nm, i, ifa.o_halt, ifa.o_trap_permission,
                   ifa.o_redirect);
        end
      end
      idle_in();
      return;
    end
    if (wr && !wr_with_mret) begin
      ifa.i_mepc_wr    = 1'b1;
      ifa.i_mepc_wdata = wd;
      m_mepc = wd;
      step();
      idle_in();
      checks++;
      if (ifa.o_mepc !== m_mepc || ifa.o_trap_permission !== 1'b1) begin
        failures++;
        $display("FAIL %s_mepc_wr got mepc=%h perm=%b want %h 1",
                 nm, ifa.o_mepc, ifa.o_trap_permission, m_mepc);
      end
    end
    ifa.i_mret = 1'b1;
    if (wr && wr_with_mret) begin
      ifa.i_mepc_wr    = 1'b1;
      ifa.i_mepc_wdata = wd;
      m_mepc = wd;
    end
    step();
    idle_in();
    checks++;
    if ({ifa.o_flush, ifa.o_redirect, ifa.o_trap_permission,
         ifa.o_halt} !== 5'b11110 || ifa.o_redirect_pc !== m_mepc) begin
      failures++;
      $display("FAIL %s_ret got=%b/%b/%b/%b pc=%h want 11/1/1/0 pc=%h",
               nm, ifa.o_flush, ifa.o_redirect,
               ifa.o_trap_permission, ifa.o_halt,
               ifa.o_redirect_pc, m_mepc);
    end
    step();
    checks++;
    if ({ifa.o_flush, ifa.o_redirect, ifa.o_trap_permission,
         ifa.o_halt} !== 5'b0 || ifa.o_mepc !== m_mepc ||
        ifa.o_mcause !== m_mcause) begin
      failures++;
      $display("FAIL %s_idle got=%b/%b/%b/%b mepc=%h want 0 mepc=%h",
               nm, ifa.o_flush, ifa.o_redirect,
               ifa.o_trap_permission, ifa.o_halt,
               ifa.o_mepc, m_mepc);
    end
  endtask

  task automatic test_ignore_outside();
    ifa.i_mret       = 1'b1;
    ifa.i_mepc_wr    = 1'b1;
    ifa.i_mepc_wdata = $urandom;
    step();
    idle_in();
    step();
    checks++;
    if (ifa.o_mepc !== m_mepc || ifa.o_redirect !== 1'b0 ||
        ifa.o_trap_permission !== 1'b0) begin
      failures++;
      $display("FAIL ignore_idle mepc=%h redir=%b perm=%b want %h 0 0",
               ifa.o_mepc, ifa.o_redirect,
               ifa.o_trap_permission, m_mepc);
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic [3:0] c1, c0;
      c1 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      c0 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      test_trap_seq(c1, c0, $urandom, $urandom, $urandom, $urandom,
                    1'($urandom), 1'($urandom), $urandom, 1'b0, "rand");
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      test_trap_seq(4'($urandom_range(1, 15)), 4'h0, $urandom, $urandom,
                    $urandom, $urandom, 1'b0, 1'b0, '0, 1'b0, "sat");
    end
    checks++;
    if (ifb.o_exc_count !== 2'b11 || ifa.o_exc_count !== 8'd5) begin
      failures++;
      $display("FAIL saturate got b=%b a=%0d want b=11 a=5",
               ifb.o_exc_count, ifa.o_exc_count);
    end
  endtask

  task automatic test_reset_mid_flush();
    ifa.i_exc_code = {4'h0, 4'h3};
    ifa.i_exc_pc   = {32'h0, 32'h1234};
    step();
    idle_in();
    checks++;
    if (ifa.o_flush !== 2'b01) begin
      failures++;
      $display("FAIL midflush_enter flush=%b want 01", ifa.o_flush);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_clear();
    checks++;
    if ({ifa.o_flush, ifa.o_redirect, ifa.o_trap_permission,
         ifa.o_halt} !== 5'b0 || ifa.o_mepc !== '0 ||
        ifa.o_exc_count !== '0) begin
      failures++;
      $display("FAIL midflush_reset flush=%b mepc=%h cnt=%0d want 0",
               ifa.o_flush, ifa.o_mepc, ifa.o_exc_count);
    end
    step();
    checks++;
    if (ifa.o_flush !== 2'b00 || ifa.o_redirect !== 1'b0) begin
      failures++;
      $display("FAIL midflush_idle flush=%b redir=%b want 0",
               ifa.o_flush, ifa.o_redirect);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_in();
    test_reset();
    test_trap_seq(4'h5, 4'h2, 32'h40, 32'h20, 32'h101, 32'h202,
                  1'b0, 1'b0, '0, 1'b0, "priority");
    test_trap_seq(4'h0, 4'h2, 32'h99, 32'h8, 32'h0, 32'h77,
                  1'b0, 1'b0, '0, 1'b0, "src0");
    test_trap_seq(4'h3, 4'h0, 32'h100, 32'h0, 32'h5, 32'h0,
                  1'b1, 1'b0, 32'h44, 1'b0, "mepc_wr");
    test_trap_seq(4'h0, 4'h8, 32'h0, 32'h200, 32'h0, 32'h9,
                  1'b1, 1'b1, 32'h88, 1'b0, "mepc_wr_mret");
    test_ignore_outside();
    test_random(20);
    test_trap_seq(4'h7, 4'h1, 32'h300, 32'h304, 32'hAA, 32'hBB,
                  1'b0, 1'b0, '0, 1'b1, "dfault");
    test_reset();
    test_saturation();
    test_reset_mid_flush();
    test_random(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
